// File: rtl/lfsr_noise_arbiter_if.sv
// Handshake bundle between the noise LFSR arbiter and its consumers / LFSR.
// master = consumer/LFSR side, slave = arbiter side.
`default_nettype none

interface lfsr_noise_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0] req;
  logic               rnd_ack;
  logic [31:0]        lfsr_data;
  logic               lfsr_en;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid;
  logic [DATA_W-1:0]  rnd_data;
  logic               busy;

  modport master (
    output req, rnd_ack, lfsr_data,
    input  lfsr_en, gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  req, rnd_ack, lfsr_data,
    output lfsr_en, gnt, rnd_valid, rnd_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_noise_arbiter.sv
// ============================================================================
// Module   : lfsr_noise_arbiter
// Purpose  : Round-robin sharing of one 32-bit Galois noise LFSR between
//            NUM_REQ consumers; steps the LFSR per grant, then hands out a
//            fresh word over a valid/ack handshake.
// Option   : LFSR_ARB_MULTISTEP_EN -- honour STEPS (8-bit step counter).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_noise_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int STEPS   = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  lfsr_noise_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic [NUM_REQ-1:0] gnt;
  logic               lfsr_en;
  logic               rnd_valid;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W:0]     scan;

`ifdef LFSR_ARB_MULTISTEP_EN
  localparam logic [7:0] CNT_LOAD = 8'(STEPS - 1);
  logic [7:0] step_cnt;
`else
  logic [7:0] unused_steps;
  assign unused_steps = 8'(STEPS);
`endif

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (scan >= (PTR_W + 1)'(NUM_REQ)) begin
        scan = scan - (PTR_W + 1)'(NUM_REQ);
      end
      if (!found && bus.req[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      gnt       <= '0;
      lfsr_en   <= 1'b0;
      rnd_valid <= 1'b0;
`ifdef LFSR_ARB_MULTISTEP_EN
      step_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= STEP;
            sel     <= pick;
            gnt     <= NUM_REQ'(1) << pick;
            lfsr_en <= 1'b1;
`ifdef LFSR_ARB_MULTISTEP_EN
            step_cnt <= CNT_LOAD;
`endif
          end
        end

        STEP: begin
`ifdef LFSR_ARB_MULTISTEP_EN
          if (step_cnt == 8'd0) begin
            state     <= DELIVER;
            lfsr_en   <= 1'b0;
            rnd_valid <= 1'b1;
          end else begin
            step_cnt <= step_cnt - 8'd1;
          end
`else
          state     <= DELIVER;
          lfsr_en   <= 1'b0;
          rnd_valid <= 1'b1;
`endif
        end

        DELIVER: begin
          // A consumer that withdraws its request forfeits the word but
          // still consumes its turn so the rotation stays fair.
          if (bus.rnd_ack || !bus.req[sel]) begin
            state     <= IDLE;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rr_ptr    <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          lfsr_en   <= 1'b0;
          rnd_valid <= 1'b0;
        end
      endcase
    end
  end

  // LFSR is frozen in DELIVER, so the word is taken straight from its output.
  assign bus.rnd_data  = rnd_valid ? bus.lfsr_data[DATA_W-1:0] : '0;
  assign bus.gnt       = gnt;
  assign bus.lfsr_en   = lfsr_en;
  assign bus.rnd_valid = rnd_valid;
  assign bus.busy      = (state != IDLE);

  if (DATA_W < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^bus.lfsr_data[31:DATA_W];
  end

endmodule

`default_nettype wire
